// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-read-port register file.
// The byte merge is defined per byte so any multiple-of-8 word width can reuse it.
package reg_file_pkg;

  typedef enum logic {
    INIT,
    READY
  } rf_state_e;

  localparam int BYTE_W = 8;

  function automatic logic [BYTE_W-1:0] byte_merge(
    input logic [BYTE_W-1:0] old_b,
    input logic [BYTE_W-1:0] new_b,
    input logic              strb
  );
    return strb ? new_b : old_b;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One read port: range check, write-first bypass merge and the registered,
// valid-qualified output.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTER_DEPTH = 16,
  parameter int ADDRESS_WIDTH  = 4,
  parameter int ZERO_REG       = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       active_i,
  input  logic                       rd_en_i,
  input  logic [ADDRESS_WIDTH-1:0]   rd_addr_i,
  input  logic [DATA_WIDTH-1:0]      mem_word_i,
  input  logic                       wr_commit_i,
  input  logic [ADDRESS_WIDTH-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH-1:0]      wr_data_i,
  input  logic [DATA_WIDTH/8-1:0]    wr_strb_i,
  output logic [DATA_WIDTH-1:0]      rd_data_o,
  output logic                       rd_valid_o,
  output logic                       addr_err_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / BYTE_W;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_L = (ADDRESS_WIDTH+1)'(REGISTER_DEPTH);

  logic                  in_range;
  logic                  zero_hit;
  logic                  bypass;
  logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;
  logic                  rd_valid_d, rd_valid_q;

  assign in_range   = {1'b0, rd_addr_i} < DEPTH_L;
  assign zero_hit   = (ZERO_REG != 0) && (rd_addr_i == '0);
  assign bypass     = wr_commit_i && (rd_addr_i == wr_addr_i);
  assign addr_err_o = active_i && rd_en_i && !in_range;
  assign rd_valid_d = active_i && rd_en_i;

  // The write commit already excludes address 0 under ZERO_REG, so bypass cannot leak it.
  always_comb begin
    rd_data_d = mem_word_i;
    if (bypass) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        rd_data_d[BYTE_W*b +: BYTE_W] = byte_merge(mem_word_i[BYTE_W*b +: BYTE_W],
                                                   wr_data_i[BYTE_W*b +: BYTE_W], wr_strb_i[b]);
      end
    end
    if (!in_range || zero_hit) begin
      rd_data_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      if (rd_valid_d) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with byte-strobed writes and a post-reset
// sequencer that clears one entry per cycle, keeping the array reset-free.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTER_DEPTH = 16,
  parameter int ADDRESS_WIDTH  = 4,
  parameter int NUM_READ_PORTS = 2,
  parameter int ZERO_REG       = 0
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_write_enable,
  input  logic [ADDRESS_WIDTH-1:0]             i_write_address,
  input  logic [DATA_WIDTH-1:0]                i_write_data,
  input  logic [DATA_WIDTH/8-1:0]              i_write_strb,
  input  logic [NUM_READ_PORTS-1:0]            i_read_enable,
  input  logic [NUM_READ_PORTS*ADDRESS_WIDTH-1:0] i_read_address,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] o_read_data,
  output logic [NUM_READ_PORTS-1:0]            o_read_valid,
  output logic                                 o_ready,
  output logic                                 o_addr_err
);

  localparam int STRB_WIDTH = DATA_WIDTH / BYTE_W;
  localparam logic [ADDRESS_WIDTH:0]   DEPTH_L  = (ADDRESS_WIDTH+1)'(REGISTER_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(REGISTER_DEPTH - 1);

  rf_state_e                 state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]  init_cnt_q, init_cnt_d;
  logic                      ready_q;
  logic                      addr_err_q, addr_err_d;
  logic [DATA_WIDTH-1:0]     mem_q [REGISTER_DEPTH];
  logic                      active;
  logic                      wr_in_range, wr_oob, wr_commit;
  logic [DATA_WIDTH-1:0]     wr_old, wr_word;
  logic [DATA_WIDTH-1:0]     rd_word [NUM_READ_PORTS];
  logic [NUM_READ_PORTS-1:0] rd_err;

  assign active      = (state_q == READY);
  assign wr_in_range = {1'b0, i_write_address} < DEPTH_L;
  assign wr_oob      = active && i_write_enable && !wr_in_range;
  assign wr_commit   = active && i_write_enable && wr_in_range &&
                       !((ZERO_REG != 0) && (i_write_address == '0));
  assign wr_old      = wr_in_range ? mem_q[i_write_address] : '0;

  always_comb begin
    wr_word = wr_old;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      wr_word[BYTE_W*b +: BYTE_W] = byte_merge(wr_old[BYTE_W*b +: BYTE_W],
                                               i_write_data[BYTE_W*b +: BYTE_W], i_write_strb[b]);
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    addr_err_d = wr_oob || (|rd_err);
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + ADDRESS_WIDTH'(1);
        if (init_cnt_q == LAST_IDX) begin
          state_d = READY;
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= (state_d == READY);
      addr_err_q <= addr_err_d;
    end
  end

  // Storage has no reset; the INIT sequencer owns the write port until READY.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (state_q == INIT) begin
        mem_q[init_cnt_q] <= '0;
      end else if (wr_commit) begin
        mem_q[i_write_address] <= wr_word;
      end
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    logic [ADDRESS_WIDTH-1:0] addr;
    assign addr       = i_read_address[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign rd_word[p] = ({1'b0, addr} < DEPTH_L) ? mem_q[addr] : '0;

    reg_file_rd_port #(
      .DATA_WIDTH     (DATA_WIDTH),
      .REGISTER_DEPTH (REGISTER_DEPTH),
      .ADDRESS_WIDTH  (ADDRESS_WIDTH),
      .ZERO_REG       (ZERO_REG)
    ) u_rd_port (
      .clk_i       (i_clk),
      .rst_i       (i_rst),
      .active_i    (active),
      .rd_en_i     (i_read_enable[p]),
      .rd_addr_i   (addr),
      .mem_word_i  (rd_word[p]),
      .wr_commit_i (wr_commit),
      .wr_addr_i   (i_write_address),
      .wr_data_i   (i_write_data),
      .wr_strb_i   (i_write_strb),
      .rd_data_o   (o_read_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .rd_valid_o  (o_read_valid[p]),
      .addr_err_o  (rd_err[p])
    );
  end

  assign o_ready    = ready_q;
  assign o_addr_err = addr_err_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: three configurations (default, ZERO_REG=1, DEPTH=12)
// share one stimulus stream and are each checked against an array-based model.
module tb_reg_file_mp;

  localparam int NK = 3;
  localparam int NP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [3:0]  wa;
  logic [31:0] wd;
  logic [3:0]  ws;
  logic [1:0]  re;
  logic [7:0]  ra;

  logic [63:0] rdat [NK];
  logic [1:0]  rvld [NK];
  logic        rdy  [NK];
  logic        aerr [NK];

  int          dep [NK];
  bit          zr  [NK];
  int          cyc [NK];
  logic [31:0] mm  [NK][16];
  logic [31:0] ed  [NK][NP];
  logic        ev  [NK][NP];
  logic        ee  [NK];
  logic        er  [NK];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_file_mp u_a (
    .i_clk(clk), .i_rst(rst), .i_write_enable(we), .i_write_address(wa),
    .i_write_data(wd), .i_write_strb(ws), .i_read_enable(re), .i_read_address(ra),
    .o_read_data(rdat[0]), .o_read_valid(rvld[0]), .o_ready(rdy[0]), .o_addr_err(aerr[0])
  );

  reg_file_mp #(.ZERO_REG(1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_write_enable(we), .i_write_address(wa),
    .i_write_data(wd), .i_write_strb(ws), .i_read_enable(re), .i_read_address(ra),
    .o_read_data(rdat[1]), .o_read_valid(rvld[1]), .o_ready(rdy[1]), .o_addr_err(aerr[1])
  );

  reg_file_mp #(.REGISTER_DEPTH(12)) u_c (
    .i_clk(clk), .i_rst(rst), .i_write_enable(we), .i_write_address(wa),
    .i_write_data(wd), .i_write_strb(ws), .i_read_enable(re), .i_read_address(ra),
    .o_read_data(rdat[2]), .o_read_valid(rvld[2]), .o_ready(rdy[2]), .o_addr_err(aerr[2])
  );

  // Reference: cycles since reset decide readiness; writes land first, then reads
  // see the updated array, which is exactly write-first behaviour.
  task automatic model_edge();
    logic [31:0] t;
    int          a;
    bit          err;
    for (int k = 0; k < NK; k++) begin
      if (rst) begin
        cyc[k] = 0; er[k] = 1'b0; ee[k] = 1'b0;
        for (int p = 0; p < NP; p++) begin ev[k][p] = 1'b0; ed[k][p] = '0; end
      end else if (cyc[k] < dep[k]) begin
        cyc[k]++;
        ee[k] = 1'b0;
        for (int p = 0; p < NP; p++) ev[k][p] = 1'b0;
        if (cyc[k] == dep[k]) begin
          er[k] = 1'b1;
          for (int i = 0; i < 16; i++) mm[k][i] = '0;
        end
      end else begin
        err = 1'b0;
        if (we) begin
          a = int'(wa);
          if (a >= dep[k]) err = 1'b1;
          else if (!(zr[k] && a == 0)) begin
            t = mm[k][a];
            for (int b = 0; b < 4; b++) if (ws[b]) t[8*b +: 8] = wd[8*b +: 8];
            mm[k][a] = t;
          end
        end
        for (int p = 0; p < NP; p++) begin
          ev[k][p] = re[p];
          if (re[p]) begin
            a = int'(ra[4*p +: 4]);
            if (a >= dep[k]) begin ed[k][p] = '0; err = 1'b1; end
            else if (zr[k] && a == 0) ed[k][p] = '0;
            else ed[k][p] = mm[k][a];
          end
        end
        ee[k] = err;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; ws = '0; re = '0; ra = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    for (int k = 0; k < NK; k++) begin
      n_chk++; if (rdy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_ready[%0d] got %0b exp 0", k, rdy[k]); end
      n_chk++; if (rvld[k] !== 2'b00) begin n_fail++; $display("FAIL reset_valid[%0d] got %b exp 00", k, rvld[k]); end
      n_chk++; if (rdat[k] !== 64'h0) begin n_fail++; $display("FAIL reset_data[%0d] got %h exp 0", k, rdat[k]); end
      n_chk++; if (aerr[k] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d] got %0b exp 0", k, aerr[k]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_init();
    int c = 0;
    while (rdy[0] !== 1'b1 && c < 40) begin
      step();
      c++;
      for (int k = 0; k < NK; k++) begin
        n_chk++; if (rdy[k] !== er[k]) begin n_fail++; $display("FAIL init_ready[%0d] cycle %0d got %0b exp %0b", k, c, rdy[k], er[k]); end
      end
    end
    n_chk++; if (c != 16) begin n_fail++; $display("FAIL init_length got %0d exp 16", c); end
    for (int a = 0; a < 16; a++) begin
      re = 2'b11; ra = {4'(15 - a), 4'(a)};
      step();
      for (int k = 0; k < NK; k++) begin
        for (int p = 0; p < NP; p++) begin
          n_chk++; if (rvld[k][p] !== ev[k][p]) begin n_fail++; $display("FAIL sweep_valid[%0d][%0d] a=%0d got %0b exp %0b", k, p, a, rvld[k][p], ev[k][p]); end
          n_chk++; if (rdat[k][32*p +: 32] !== ed[k][p]) begin n_fail++; $display("FAIL sweep_data[%0d][%0d] a=%0d got %h exp %h", k, p, a, rdat[k][32*p +: 32], ed[k][p]); end
        end
        n_chk++; if (aerr[k] !== ee[k]) begin n_fail++; $display("FAIL sweep_err[%0d] a=%0d got %0b exp %0b", k, a, aerr[k], ee[k]); end
      end
      n_chk++; if (rdat[0] !== 64'h0) begin n_fail++; $display("FAIL sweep_zero a=%0d got %h exp 0", a, rdat[0]); end
    end
    idle();
  endtask

  task automatic test_strobe();
    we = 1'b1; wa = 4'd3; wd = 32'hAABBCCDD; ws = 4'hF;
    step();
    wd = 32'h11223344; ws = 4'b0101;
    step();
    idle(); re = 2'b01; ra = 8'h03;
    step();
    n_chk++; if (rdat[0][31:0] !== 32'hAA22CC44) begin n_fail++; $display("FAIL strobe_data got %h exp aa22cc44", rdat[0][31:0]); end
    for (int k = 0; k < NK; k++) begin
      n_chk++; if (rdat[k][31:0] !== ed[k][0] || rvld[k][0] !== ev[k][0]) begin n_fail++; $display("FAIL strobe_model[%0d] got %h/%0b exp %h/%0b", k, rdat[k][31:0], rvld[k][0], ed[k][0], ev[k][0]); end
    end
    idle();
  endtask

  task automatic test_bypass();
    we = 1'b1; ws = 4'hF; wa = 4'd5; wd = 32'h5;
    step();
    wa = 4'd2; wd = 32'h2;
    step();
    wa = 4'd5; wd = 32'hDEADBEEF; re = 2'b11; ra = {4'd2, 4'd5};
    step();
    idle();
    n_chk++; if (rdat[0] !== {32'h2, 32'hDEADBEEF}) begin n_fail++; $display("FAIL bypass_data got %h exp 00000002deadbeef", rdat[0]); end
    n_chk++; if (rvld[0] !== 2'b11) begin n_fail++; $display("FAIL bypass_valid got %b exp 11", rvld[0]); end
    for (int k = 0; k < NK; k++) begin
      for (int p = 0; p < NP; p++) begin
        n_chk++; if (rdat[k][32*p +: 32] !== ed[k][p]) begin n_fail++; $display("FAIL bypass_model[%0d][%0d] got %h exp %h", k, p, rdat[k][32*p +: 32], ed[k][p]); end
      end
    end
  endtask

  task automatic test_zero();
    we = 1'b1; wa = 4'd0; wd = 32'h12345678; ws = 4'hF;
    step();
    n_chk++; if (aerr[1] !== 1'b0) begin n_fail++; $display("FAIL zero_write_err got %0b exp 0", aerr[1]); end
    idle(); re = 2'b11; ra = 8'h00;
    step();
    idle();
    n_chk++; if (rdat[1] !== 64'h0 || rvld[1] !== 2'b11) begin n_fail++; $display("FAIL zero_read got %h/%b exp 0/11", rdat[1], rvld[1]); end
    n_chk++; if (aerr[1] !== 1'b0) begin n_fail++; $display("FAIL zero_read_err got %0b exp 0", aerr[1]); end
    n_chk++; if (rdat[0] !== {2{32'h12345678}}) begin n_fail++; $display("FAIL nonzero_reg0 got %h exp 1234567812345678", rdat[0]); end
  endtask

  task automatic test_oob();
    we = 1'b1; wa = 4'd13; wd = 32'hCAFEF00D; ws = 4'hF; re = 2'b01; ra = 8'h0E;
    step();
    idle();
    n_chk++; if (rdat[2][31:0] !== 32'h0 || rvld[2][0] !== 1'b1) begin n_fail++; $display("FAIL oob_read got %h/%0b exp 0/1", rdat[2][31:0], rvld[2][0]); end
    n_chk++; if (aerr[2] !== 1'b1) begin n_fail++; $display("FAIL oob_err_pulse got %0b exp 1", aerr[2]); end
    n_chk++; if (aerr[0] !== 1'b0) begin n_fail++; $display("FAIL oob_err_full_depth got %0b exp 0", aerr[0]); end
    step();
    n_chk++; if (aerr[2] !== 1'b0) begin n_fail++; $display("FAIL oob_err_single got %0b exp 0", aerr[2]); end
    for (int a = 0; a < 12; a++) begin
      re = 2'b11; ra = {4'(a), 4'(11 - a)};
      step();
      for (int p = 0; p < NP; p++) begin
        n_chk++; if (rdat[2][32*p +: 32] !== ed[2][p]) begin n_fail++; $display("FAIL oob_sweep[%0d] a=%0d got %h exp %h", p, a, rdat[2][32*p +: 32], ed[2][p]); end
      end
      n_chk++; if (aerr[2] !== 1'b0) begin n_fail++; $display("FAIL oob_sweep_err a=%0d got %0b exp 0", a, aerr[2]); end
    end
    idle();
  endtask

  task automatic test_hold();
    re = 2'b01; ra = 8'h03;
    step();
    re = 2'b00; ra = 8'h55;
    step();
    n_chk++; if (rvld[0] !== 2'b00) begin n_fail++; $display("FAIL hold_valid got %b exp 00", rvld[0]); end
    n_chk++; if (rdat[0][31:0] !== 32'hAA22CC44) begin n_fail++; $display("FAIL hold_data got %h exp aa22cc44", rdat[0][31:0]); end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom); wa = 4'($urandom); wd = $urandom; ws = 4'($urandom);
      re = 2'($urandom); ra = 8'($urandom);
      if ($urandom_range(0, 2) == 0) ra[3:0] = wa;
      step();
      for (int k = 0; k < NK; k++) begin
        for (int p = 0; p < NP; p++) begin
          n_chk++; if (rvld[k][p] !== ev[k][p]) begin n_fail++; $display("FAIL rand_valid[%0d][%0d] i=%0d got %0b exp %0b", k, p, i, rvld[k][p], ev[k][p]); end
          n_chk++; if (rdat[k][32*p +: 32] !== ed[k][p]) begin n_fail++; $display("FAIL rand_data[%0d][%0d] i=%0d got %h exp %h", k, p, i, rdat[k][32*p +: 32], ed[k][p]); end
        end
        n_chk++; if (aerr[k] !== ee[k]) begin n_fail++; $display("FAIL rand_err[%0d] i=%0d got %0b exp %0b", k, i, aerr[k], ee[k]); end
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_init();
    int c = 0;
    re = 2'b11; ra = 8'h21; rst = 1'b1;
    step();
    for (int k = 0; k < NK; k++) begin
      n_chk++; if (rvld[k] !== 2'b00) begin n_fail++; $display("FAIL rst_discard[%0d] got %b exp 00", k, rvld[k]); end
    end
    idle();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    while (rdy[0] !== 1'b1 && c < 40) begin
      we = (c == 2); wa = 4'd1; wd = 32'hFFFFFFFF; ws = 4'hF;
      step();
      c++;
      for (int k = 0; k < NK; k++) begin
        n_chk++; if (rdy[k] !== er[k]) begin n_fail++; $display("FAIL reinit_ready[%0d] cycle %0d got %0b exp %0b", k, c, rdy[k], er[k]); end
      end
    end
    n_chk++; if (c != 16) begin n_fail++; $display("FAIL reinit_length got %0d exp 16", c); end
    idle(); re = 2'b11; ra = 8'h11;
    step();
    idle();
    n_chk++; if (rdat[0] !== 64'h0 || rvld[0] !== 2'b11) begin n_fail++; $display("FAIL init_write_ignored got %h/%b exp 0/11", rdat[0], rvld[0]); end
    for (int k = 0; k < NK; k++) begin
      n_chk++; if (rdat[k][31:0] !== ed[k][0]) begin n_fail++; $display("FAIL reinit_model[%0d] got %h exp %h", k, rdat[k][31:0], ed[k][0]); end
    end
  endtask

  initial begin
    dep[0] = 16; dep[1] = 16; dep[2] = 12;
    zr[0]  = 1'b0; zr[1] = 1'b1; zr[2] = 1'b0;
    for (int k = 0; k < NK; k++) begin
      cyc[k] = 0; ee[k] = 1'b0; er[k] = 1'b0;
      for (int i = 0; i < 16; i++) mm[k][i] = '0;
      for (int p = 0; p < NP; p++) begin ed[k][p] = '0; ev[k][p] = 1'b0; end
    end
    rst = 1'b1;
    idle();
    test_reset();
    test_init();
    test_strobe();
    test_bypass();
    test_zero();
    test_oob();
    test_hold();
    test_random();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
